csr_regblock_responder: RTL and testbench
=========================================

Name: csr_regblock_responder

Overview:
- Register-map end of the bus request/response channel: consumes bus_req/addr/wr_data/wr_biten/stall and returns bus_ready/bus_rd_data/bus_err.
- Holds NUM_REGS word registers: register 0 is a read-only ID, the rest are read/write with per-bit write enables.
- Sits between the APB4 slave front-end and hardware logic, which consumes the register contents.
- Supports back-pressure via the stall inputs and a configurable response latency.

Parameters:
- DATA_WIDTH, 32, data/bit-enable width.
- ADDR_WIDTH, 11, byte address width.
- NUM_REGS, 16, number of word registers (2..2^(ADDR_WIDTH-2)).
- WAIT_CYCLES, 0, extra cycles between acceptance and response (0..15).
- ID_VALUE, 32'hC5A0_0001, constant returned by register 0.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- bus_req  input  1  single-cycle request strobe.
- bus_req_is_wr  input  1  1=write, 0=read; valid with bus_req.
- bus_addr  input  ADDR_WIDTH  byte address; valid with bus_req.
- bus_wr_data  input  DATA_WIDTH  write data; valid with bus_req.
- bus_wr_biten  input  DATA_WIDTH  per-bit write enable; valid with bus_req.
- bus_req_stall_wr  input  1  holds completion of a pending write while high.
- bus_req_stall_rd  input  1  holds completion of a pending read while high.
- bus_ready  output  1  one-cycle response strobe.
- bus_rd_data  output  DATA_WIDTH  read data, valid only with bus_ready.
- bus_err  output  1  error flag, valid only with bus_ready.
- reg_q  output  NUM_REGS*DATA_WIDTH  flattened register contents to hardware, reg i at [i*DATA_WIDTH +: DATA_WIDTH].
- reg_wr_pulse  output  NUM_REGS  one-cycle pulse on the cycle a register is committed.

Behaviour:
- Clock/reset (fixed): single clock clk; rst is synchronous, active-high.
- Reset values:
  - bus_ready=0, bus_err=0, bus_rd_data=0, reg_wr_pulse=0, FSM=IDLE, wait counter=0.
  - reg 0 reads ID_VALUE; regs 1..NUM_REGS-1 = 0.
- FSM states: IDLE, STALL, WAIT, RESP.
  - IDLE: on bus_req=1, latch is_wr/addr/wr_data/wr_biten and decode. Next state: STALL if the matching stall is high that cycle, else WAIT if WAIT_CYCLES>0, else RESP.
  - STALL: stay while the matching stall (wr for writes, rd for reads) is high. On deassertion go to WAIT (WAIT_CYCLES>0) or RESP. The non-matching stall is ignored.
  - WAIT: count WAIT_CYCLES cycles, then go to RESP.
  - RESP: bus_ready=1 for exactly one cycle, then return to IDLE.
- Latency: with no stall and WAIT_CYCLES=0, bus_req in cycle T gives bus_ready in T+1. In general, response arrives at T+1+stall cycles+WAIT_CYCLES.
- Decode (on latched address):
  - index = addr[ADDR_WIDTH-1:2].
  - err if addr[1:0]!=0, or index>=NUM_REGS, or (write and index==0).
- Write commit:
  - Occurs in the RESP cycle only when err=0: reg[i] <= (reg[i] & ~biten) | (wdata & biten).
  - reg_wr_pulse[i]=1 in that same RESP cycle; the new value is visible on reg_q from RESP+1.
  - biten=0 still pulses and completes OK with value unchanged.
- Read: bus_rd_data = reg[index] (ID_VALUE for index 0) in RESP, else 0.
- Zero-data cases: bus_rd_data=0 for writes and for errored accesses.
- bus_err: 0 outside RESP.
- Busy: bus_req while not IDLE is a protocol violation, ignored with no state change. The same applies to bus_req in the RESP cycle; a new request is accepted only from IDLE.
- Reset mid-transaction: the transaction is abandoned. No bus_ready, no commit; all registers return to reset values.
- Back-to-back: req at T, ready at T+1, next req at T+2 is accepted. Throughput is one access per 2 cycles minimum.

Decomposition:
- Package csr_resp_pkg:
  - state_t enum {IDLE, STALL, WAIT, RESP}.
  - ADDR_LSB=2.
  - Default ID_VALUE constant.
  - Function to compute the decode error.
- Sub-module csr_reg_array:
  - Storage of NUM_REGS-1 RW registers with bit-enable write port, commit strobe and wr_pulse generation.
  - The responder FSM, decode and read mux stay in the top.

Test Plan:
- Read ID: req rd addr 0x000 -> ready at T+1, rd_data=0xC5A00001, err=0.
- Masked write then readback:
  - Initial value: reg 3 = 0.
  - Write addr 0x00C, wdata=0xFFFF_FFFF, biten=0x0000_FF00 -> err=0, reg_wr_pulse[3] at ready.
  - Read 0x00C -> 0x0000_FF00.
- Errors, each -> bus_err=1 and no register change:
  - Write 0x000 (ID register).
  - Read 0x002 (misaligned) -> rd_data=0.
  - Read 0x040 with NUM_REGS=16 (out of range) -> rd_data=0.
- Stall:
  - Write with stall_wr high for 3 cycles from T -> ready at T+4.
  - stall_rd high during a write -> no effect, ready at T+1.
- WAIT_CYCLES=3: read at T -> ready at T+4; bus_req at T+2 ignored, no second ready.
- Reset mid-op: write accepted, rst asserted in WAIT/STALL -> no ready, reg unchanged/reset, next req serviced normally.

Source files
------------

// File: rtl/csr_resp_pkg.sv
// Shared types and helpers for the CSR register-block responder.
// Holds the FSM state encoding, the word-address offset, the default ID and the access decode check.
package csr_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int ADDR_LSB = 2;
    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hC5A0_0001;

    // An access errors on a misaligned byte offset, an unmapped index or a write to the ID word
    function automatic logic decode_err(input logic [1:0] byte_off, input int unsigned index,
                                        input int unsigned num_regs, input logic is_wr);
        return (byte_off != 2'b00) || (index >= num_regs) || (is_wr && (index == 32'd0));
    endfunction

endpackage

// File: rtl/csr_reg_array.sv
// Read/write register storage for indices 1..NUM_REGS-1.
// A commit strobe raises a one-cycle write pulse, and the register merges the held data on that pulse.
module csr_reg_array #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = 9
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 commit_stb,
    input  logic [IDX_W-1:0]                     commit_idx,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic [DATA_WIDTH-1:0]                wr_biten,
    output logic [(NUM_REGS-1)*DATA_WIDTH-1:0]   q,
    output logic [NUM_REGS-2:0]                  wr_pulse
);

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS-1];
    logic [NUM_REGS-2:0]   wr_pulse_r;

    // The pulse marks the response cycle; data merges at its end so the new value shows one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pulse_r <= {(NUM_REGS-1){1'b0}};
            for (int j = 0; j < NUM_REGS - 1; j++) begin
                regs_r[j] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int j = 0; j < NUM_REGS - 1; j++) begin
                wr_pulse_r[j] <= commit_stb && (commit_idx == IDX_W'(j + 1));
                if (wr_pulse_r[j]) begin
                    regs_r[j] <= (regs_r[j] & ~wr_biten) | (wr_data & wr_biten);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_flat
        assign q[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
    end

    assign wr_pulse = wr_pulse_r;

endmodule

// File: rtl/csr_regblock_responder.sv
// Register-map responder: accepts single-cycle bus requests, applies stall and latency, and answers with a one-cycle ready.
// Register 0 is a constant ID; the remaining registers live in csr_reg_array.
module csr_regblock_responder
    import csr_resp_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 11,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           bus_req,
    input  logic                           bus_req_is_wr,
    input  logic [ADDR_WIDTH-1:0]          bus_addr,
    input  logic [DATA_WIDTH-1:0]          bus_wr_data,
    input  logic [DATA_WIDTH-1:0]          bus_wr_biten,
    input  logic                           bus_req_stall_wr,
    input  logic                           bus_req_stall_rd,
    output logic                           bus_ready,
    output logic [DATA_WIDTH-1:0]          bus_rd_data,
    output logic                           bus_err,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int IDX_W = ADDR_WIDTH - ADDR_LSB;

    state_t                  state_r, state_nxt_s;
    logic [3:0]              wait_cnt_r;
    logic                    is_wr_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r, biten_r;
    logic                    ready_r, err_r;
    logic [DATA_WIDTH-1:0]   rd_data_r;

    logic                    cur_is_wr_s, cur_err_s, enter_resp_s, stall_s;
    logic [ADDR_WIDTH-1:0]   cur_addr_s;
    logic [IDX_W-1:0]        cur_idx_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;
    logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_s;
    logic [(NUM_REGS-1)*DATA_WIDTH-1:0] arr_q_s;
    logic [NUM_REGS-2:0]     arr_pulse_s;

    // Responses are registered at entry to RESP, so decode must see the live request when leaving IDLE
    always_comb begin
        cur_is_wr_s = (state_r == ST_IDLE) ? bus_req_is_wr : is_wr_r;
        cur_addr_s  = (state_r == ST_IDLE) ? bus_addr : addr_r;
        cur_idx_s   = cur_addr_s[ADDR_WIDTH-1:ADDR_LSB];
        cur_err_s   = decode_err(cur_addr_s[1:0], int'(cur_idx_s), NUM_REGS, cur_is_wr_s);
        stall_s     = cur_is_wr_s ? bus_req_stall_wr : bus_req_stall_rd;
    end

    // Next-state logic; requests outside IDLE are ignored
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!bus_req) begin
                    state_nxt_s = ST_IDLE;
                end else if (stall_s) begin
                    state_nxt_s = ST_STALL;
                end else if (WAIT_CYCLES > 0) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_STALL: begin
                if (stall_s) begin
                    state_nxt_s = ST_STALL;
                end else if (WAIT_CYCLES > 0) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'(WAIT_CYCLES - 1)) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
        enter_resp_s = (state_nxt_s == ST_RESP) && (state_r != ST_RESP);
    end

    // Read mux over the flattened register image, including the ID word
    always_comb begin
        rd_word_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_word_s = (cur_idx_s == IDX_W'(i)) ? reg_q_s[i*DATA_WIDTH +: DATA_WIDTH] : rd_word_s;
        end
    end

    // FSM state, request capture, wait counter and registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            is_wr_r    <= 1'b0;
            addr_r     <= {ADDR_WIDTH{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
            biten_r    <= {DATA_WIDTH{1'b0}};
            ready_r    <= 1'b0;
            err_r      <= 1'b0;
            rd_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_IDLE) && bus_req) begin
                is_wr_r <= bus_req_is_wr;
                addr_r  <= bus_addr;
                wdata_r <= bus_wr_data;
                biten_r <= bus_wr_biten;
            end
            wait_cnt_r <= (state_r == ST_WAIT) ? wait_cnt_r + 4'd1 : 4'd0;
            ready_r    <= enter_resp_s;
            err_r      <= enter_resp_s && cur_err_s;
            rd_data_r  <= (enter_resp_s && !cur_err_s && !cur_is_wr_s) ? rd_word_s : {DATA_WIDTH{1'b0}};
        end
    end

    csr_reg_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W)
    ) u_reg_array (
        .clk       (clk),
        .rst       (rst),
        .commit_stb(enter_resp_s && cur_is_wr_s && !cur_err_s),
        .commit_idx(cur_idx_s),
        .wr_data   (wdata_r),
        .wr_biten  (biten_r),
        .q         (arr_q_s),
        .wr_pulse  (arr_pulse_s)
    );

    assign reg_q_s      = {arr_q_s, ID_VALUE};
    assign reg_q        = reg_q_s;
    assign reg_wr_pulse = {arr_pulse_s, 1'b0};
    assign bus_ready    = ready_r;
    assign bus_err      = err_r;
    assign bus_rd_data  = rd_data_r;

endmodule

// File: tb/tb_csr_regblock_responder.sv
// Directed scoreboard bench: one responder with no added latency and one with WAIT_CYCLES=3.
// Expected responses are queued at request time and checked when ready appears.
module tb_csr_regblock_responder;

    localparam logic [31:0] ID = 32'hC5A0_0001;

    typedef struct {
        logic [31:0] d;
        logic        e;
        logic [15:0] p;
        int          c;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, bus_req, req_w, is_wr, stall_wr, stall_rd;
    logic [10:0]  addr;
    logic [31:0]  wdata, biten;
    logic         rdy0, err0, rdyw, errw;
    logic [31:0]  rdata0, rdataw;
    logic [511:0] q0, qw;
    logic [15:0]  pulse0, pulsew;

    int           cyc = 0;
    int           n_cmp = 0;
    int           n_mis = 0;
    exp_t         exp_q[$];
    exp_t         exp_w_q[$];
    logic [31:0]  model [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csr_regblock_responder dut (
        .clk(clk), .rst(rst), .bus_req(bus_req), .bus_req_is_wr(is_wr), .bus_addr(addr),
        .bus_wr_data(wdata), .bus_wr_biten(biten), .bus_req_stall_wr(stall_wr),
        .bus_req_stall_rd(stall_rd), .bus_ready(rdy0), .bus_rd_data(rdata0), .bus_err(err0),
        .reg_q(q0), .reg_wr_pulse(pulse0)
    );

    csr_regblock_responder #(.WAIT_CYCLES(3)) dut_w (
        .clk(clk), .rst(rst), .bus_req(req_w), .bus_req_is_wr(is_wr), .bus_addr(addr),
        .bus_wr_data(wdata), .bus_wr_biten(biten), .bus_req_stall_wr(stall_wr),
        .bus_req_stall_rd(stall_rd), .bus_ready(rdyw), .bus_rd_data(rdataw), .bus_err(errw),
        .reg_q(qw), .reg_wr_pulse(pulsew)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] flat(input bit use_model);
        logic [511:0] f;
        f = 512'd0;
        f[31:0] = ID;
        for (int i = 1; i < 16; i++) begin
            f[i*32 +: 32] = use_model ? model[i] : 32'd0;
        end
        return f;
    endfunction

    // Advance to the next falling edge and score both responders
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (rdy0) begin
            chk("unexpected_ready0", 512'(exp_q.size() != 0), 512'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("latency0", 512'(cyc), 512'(e.c));
                chk("rd_data0", 512'(rdata0), 512'(e.d));
                chk("err0", 512'(err0), 512'(e.e));
                chk("pulse0", 512'(pulse0), 512'(e.p));
            end
        end else begin
            chk("idle_out0", 512'({err0, rdata0, pulse0}), 512'd0);
        end
        if (rdyw) begin
            chk("unexpected_ready_w", 512'(exp_w_q.size() != 0), 512'd1);
            if (exp_w_q.size() != 0) begin
                e = exp_w_q.pop_front();
                chk("latency_w", 512'(cyc), 512'(e.c));
                chk("rd_data_w", 512'(rdataw), 512'(e.d));
                chk("err_w", 512'(errw), 512'(e.e));
                chk("pulse_w", 512'(pulsew), 512'(e.p));
            end
        end else begin
            chk("idle_out_w", 512'({errw, rdataw, pulsew}), 512'd0);
        end
    endtask

    task automatic send(input bit tow, input logic wr, input logic [10:0] a, input logic [31:0] d,
                        input logic [31:0] b, input logic [31:0] ed, input logic ee, input int extra);
        logic [15:0] p;
        int idx;
        idx = int'(a[10:2]);
        p = (wr && !ee) ? (16'd1 << idx) : 16'd0;
        is_wr = wr; addr = a; wdata = d; biten = b;
        if (tow) begin
            req_w = 1'b1;
            exp_w_q.push_back('{ed, ee, p, cyc + 1 + extra});
        end else begin
            bus_req = 1'b1;
            exp_q.push_back('{ed, ee, p, cyc + 1 + extra});
            if (wr && !ee) model[idx] = (model[idx] & ~b) | (d & b);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (exp_q.size() + exp_w_q.size()) != 0; i++) step();
        chk("response_timeout", 512'(exp_q.size() + exp_w_q.size()), 512'd0);
        step();
    endtask

    task automatic access(input bit tow, input logic wr, input logic [10:0] a, input logic [31:0] d,
                          input logic [31:0] b, input logic [31:0] ed, input logic ee, input int extra);
        send(tow, wr, a, d, b, ed, ee, extra);
        step();
        bus_req = 1'b0; req_w = 1'b0;
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bus_req = 1'b0; req_w = 1'b0; is_wr = 1'b0; stall_wr = 1'b0; stall_rd = 1'b0;
        addr = 11'd0; wdata = 32'd0; biten = 32'd0;
        for (int i = 0; i < 16; i++) model[i] = 32'd0;
        step(); step();
        chk("reset_regq0", q0, flat(1'b0));
        chk("reset_regq_w", qw, flat(1'b0));
        rst = 1'b0;
        step();

        // Basic reads and masked writes
        access(0, 1'b0, 11'h000, 32'd0, 32'd0, ID, 1'b0, 0);
        access(0, 1'b1, 11'h00C, 32'hFFFF_FFFF, 32'h0000_FF00, 32'd0, 1'b0, 0);
        chk("regq_masked", q0, flat(1'b1));
        access(0, 1'b0, 11'h00C, 32'd0, 32'd0, 32'h0000_FF00, 1'b0, 0);
        access(0, 1'b1, 11'h00C, 32'h1234_5678, 32'hFFFF_0000, 32'd0, 1'b0, 0);
        access(0, 1'b0, 11'h00C, 32'd0, 32'd0, 32'h1234_FF00, 1'b0, 0);
        access(0, 1'b1, 11'h03C, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
        access(0, 1'b0, 11'h03C, 32'd0, 32'd0, 32'hA5A5_5A5A, 1'b0, 0);
        access(0, 1'b1, 11'h00C, 32'hFFFF_FFFF, 32'h0000_0000, 32'd0, 1'b0, 0);
        access(0, 1'b0, 11'h00C, 32'd0, 32'd0, 32'h1234_FF00, 1'b0, 0);

        // Error cases leave every register untouched
        access(0, 1'b1, 11'h000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
        access(0, 1'b0, 11'h002, 32'd0, 32'd0, 32'd0, 1'b1, 0);
        access(0, 1'b0, 11'h040, 32'd0, 32'd0, 32'd0, 1'b1, 0);
        access(0, 1'b1, 11'h040, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
        access(0, 1'b1, 11'h00D, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
        chk("regq_after_errors", q0, flat(1'b1));

        // Read stall is ignored for a write
        stall_rd = 1'b1;
        access(0, 1'b1, 11'h008, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
        stall_rd = 1'b0;
        access(0, 1'b0, 11'h008, 32'd0, 32'd0, 32'hCAFE_F00D, 1'b0, 0);

        // Write stalled three cycles; a request during the stall is ignored
        stall_wr = 1'b1;
        send(0, 1'b1, 11'h010, 32'h0BAD_BEEF, 32'h0000_FFFF, 32'd0, 1'b0, 3);
        step();
        bus_req = 1'b0;
        step();
        bus_req = 1'b1; is_wr = 1'b1; addr = 11'h014; wdata = 32'hFFFF_FFFF; biten = 32'hFFFF_FFFF;
        step();
        bus_req = 1'b0; stall_wr = 1'b0;
        drain();
        chk("regq_after_stall", q0, flat(1'b1));
        access(0, 1'b0, 11'h010, 32'd0, 32'd0, 32'h0000_BEEF, 1'b0, 0);

        // Read stalled two cycles
        stall_rd = 1'b1;
        send(0, 1'b0, 11'h010, 32'd0, 32'd0, 32'h0000_BEEF, 1'b0, 2);
        step();
        bus_req = 1'b0;
        step();
        stall_rd = 1'b0;
        drain();

        // Reset while a write is stalled abandons it and clears the registers
        stall_wr = 1'b1;
        bus_req = 1'b1; is_wr = 1'b1; addr = 11'h014; wdata = 32'hFFFF_FFFF; biten = 32'hFFFF_FFFF;
        step();
        bus_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; stall_wr = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 32'd0;
        step();
        chk("regq_after_midop_reset", q0, flat(1'b1));
        access(0, 1'b0, 11'h00C, 32'd0, 32'd0, 32'd0, 1'b0, 0);
        access(0, 1'b0, 11'h014, 32'd0, 32'd0, 32'd0, 1'b0, 0);

        // WAIT_CYCLES=3: ready at T+4, a request at T+2 is ignored
        send(1, 1'b0, 11'h000, 32'd0, 32'd0, ID, 1'b0, 3);
        step();
        req_w = 1'b0;
        step();
        req_w = 1'b1; is_wr = 1'b1; addr = 11'h004; wdata = 32'hFFFF_FFFF; biten = 32'hFFFF_FFFF;
        step();
        req_w = 1'b0;
        drain();
        step(); step(); step();
        chk("regq_w_after_busy", qw, flat(1'b0));

        // Reset during WAIT abandons the read; the next one is serviced normally
        req_w = 1'b1; is_wr = 1'b0; addr = 11'h03C;
        step();
        req_w = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        access(1, 1'b0, 11'h000, 32'd0, 32'd0, ID, 1'b0, 3);
        access(1, 1'b0, 11'h002, 32'd0, 32'd0, 32'd0, 1'b1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
